// File: rtl/dft_pkg.sv
// rtl/dft_pkg.sv - shared constants, types and twiddle ROM for the 16-point serial DFT
package dft_pkg;

  localparam int N    = 16;
  localparam int XW   = 4;
  localparam int TWF  = 16;
  localparam int ACCW = 26;

  typedef logic signed [ACCW-1:0] fx_acc_t;
  typedef logic [63:0]            f64_t;
  typedef logic signed [TWF+1:0]  tw_t;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // |cos| of 0, 22.5, 45, 67.5, 90 degrees in Q1.16
  localparam tw_t TW_MAG [5] = '{18'sd65536, 18'sd60547, 18'sd46341, 18'sd25080, 18'sd0};

  // Quadrant folding: angle = 90*m[3:2] + 22.5*m[1:0]
  function automatic tw_t tw_lookup(input logic [3:0] m, input logic want_sin);
    logic [2:0] r;
    logic [2:0] rc;
    tw_t        a;
    tw_t        b;
    r  = {1'b0, m[1:0]};
    rc = 3'd4 - r;
    a  = TW_MAG[r];
    b  = TW_MAG[rc];
    case (m[3:2])
      2'd0:    return want_sin ? b  : a;
      2'd1:    return want_sin ? a  : -b;
      2'd2:    return want_sin ? -b : -a;
      default: return want_sin ? -a : b;
    endcase
  endfunction

endpackage

// File: rtl/dft_if.sv
// rtl/dft_if.sv - host-side bus of the DFT block; DFT_INVERSE_EN adds the inv request bit
interface dft_if;
  import dft_pkg::*;

  logic                   start;
  logic [N*XW-1:0]        x_i;
`ifdef DFT_INVERSE_EN
  logic                   inv;
`endif
  logic                   busy;
  logic                   done;
  logic [N*128-1:0]       px_o;

  modport master (
    output start, x_i,
`ifdef DFT_INVERSE_EN
    output inv,
`endif
    input  busy, done, px_o
  );

  modport slave (
    input  start, x_i,
`ifdef DFT_INVERSE_EN
    input  inv,
`endif
    output busy, done, px_o
  );

endinterface

// File: rtl/dft_fx2dbl.sv
// rtl/dft_fx2dbl.sv - exact combinational signed Q.16 accumulator to IEEE-754 double
module fx2dbl
  import dft_pkg::*;
(
  input  fx_acc_t acc,
  output f64_t    dbl
);

  logic [ACCW-1:0] mag;
  logic [4:0]      p;
  logic [51:0]     mant;

  always_comb begin
    mag = acc[ACCW-1] ? $unsigned(-acc) : $unsigned(acc);
    p   = '0;
    for (int i = 0; i < ACCW; i++) begin
      if (mag[i]) p = 5'(i);
    end
    // leading one lands on bit 52 and falls off, leaving the fraction left-aligned
    mant = 52'(mag) << (6'd52 - {1'b0, p});
    if (mag == '0) dbl = '0;
    else           dbl = {acc[ACCW-1], 11'd1007 + {6'd0, p}, mant};
  end

endmodule

// File: rtl/dft.sv
// rtl/dft.sv - 16-point serial DFT, one complex MAC per cycle; DFT_INVERSE_EN selects conjugate twiddles
module dft
  import dft_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  dft_if.slave  bus
);

  state_t          state_q, state_d;
  logic [3:0]      k_q, n_q;
  logic [N*XW-1:0] x_q;
  fx_acc_t         acc_re_q, acc_im_q;
  logic [N*128-1:0] px_q;
`ifdef DFT_INVERSE_EN
  logic            inv_q;
`endif

  logic [3:0]  m;
  logic [XW-1:0] xn;
  tw_t         c_w, s_w;
  fx_acc_t     x_s, c_s, s_s, p_re, p_im, acc_re_nxt, acc_im_nxt;
  f64_t        dbl_re, dbl_im;
  logic        last_n, last_k;

  assign m      = k_q * n_q;
  assign xn     = x_q[XW*n_q +: XW];
  assign c_w    = tw_lookup(m, 1'b0);
  assign s_w    = tw_lookup(m, 1'b1);
  assign x_s    = {{(ACCW-XW){1'b0}}, xn};
  assign c_s    = {{(ACCW-TWF-2){c_w[TWF+1]}}, c_w};
  assign s_s    = {{(ACCW-TWF-2){s_w[TWF+1]}}, s_w};
  assign p_re   = x_s * c_s;
  assign p_im   = x_s * s_s;
  assign acc_re_nxt = acc_re_q + p_re;
`ifdef DFT_INVERSE_EN
  assign acc_im_nxt = inv_q ? acc_im_q + p_im : acc_im_q - p_im;
`else
  assign acc_im_nxt = acc_im_q - p_im;
`endif
  assign last_n = (n_q == 4'd15);
  assign last_k = (k_q == 4'd15);

  fx2dbl u_cvt_re (.acc(acc_re_nxt), .dbl(dbl_re));
  fx2dbl u_cvt_im (.acc(acc_im_nxt), .dbl(dbl_im));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    if (last_n && last_k) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.px_o = px_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      n_q      <= '0;
      x_q      <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      px_q     <= '0;
`ifdef DFT_INVERSE_EN
      inv_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.start) begin
        x_q      <= bus.x_i;
        k_q      <= '0;
        n_q      <= '0;
        acc_re_q <= '0;
        acc_im_q <= '0;
`ifdef DFT_INVERSE_EN
        inv_q    <= bus.inv;
`endif
      end else if (state_q == CALC) begin
        n_q <= n_q + 4'd1;
        if (last_n) begin
          // final term is folded in combinationally so the bin lands this cycle
          px_q[128*k_q +: 64]      <= dbl_re;
          px_q[128*k_q + 64 +: 64] <= dbl_im;
          acc_re_q <= '0;
          acc_im_q <= '0;
          k_q      <= k_q + 4'd1;
        end else begin
          acc_re_q <= acc_re_nxt;
          acc_im_q <= acc_im_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_dft.sv
// tb/tb_dft.sv - self-checking bench for dft against a floating-point DFT model
module tb_dft;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dft_if bus_if ();
  dft u_dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

  int   total = 0;
  int   bad = 0;
  logic inv_val = 1'b0;
  int   first_done, n_done;
  logic [63:0] xv;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic [63:0] obs_bits, input real exp, input real tol);
    real obs;
    bit  ok;
    obs = $bitstoreal(obs_bits);
    ok  = !$isunknown(obs_bits) && (obs - exp < tol) && (exp - obs < tol);
    total++;
    assert (ok) else begin
      bad++;
      $error("FAIL %s observed=%f expected=%f tol=%g", tag, obs, exp, tol);
    end
  endtask

  // Reference: direct DFT in reals; bins whose twiddles are all 0/+-1 use exact integer sums
  task automatic check_bins(input string tag, input logic [63:0] x, input bit strict_zero);
    for (int k = 0; k < 16; k++) begin
      real re, im, sx, ang, sgn;
      int  ire, iim, xn, m;
      bit  exact;
      logic [63:0] got_re, got_im;
      re = 0.0; im = 0.0; sx = 0.0; ire = 0; iim = 0; exact = 1;
      sgn = inv_val ? 1.0 : -1.0;
      for (int n = 0; n < 16; n++) begin
        xn  = int'(x[4*n +: 4]);
        m   = (k * n) % 16;
        ang = 2.0 * 3.14159265358979323846 * real'(k * n) / 16.0;
        re  = re + real'(xn) * $cos(ang);
        im  = im + sgn * real'(xn) * $sin(ang);
        sx  = sx + real'(xn);
        if (xn != 0 && (m % 4) != 0) exact = 0;
        if (m == 0) ire += xn;
        if (m == 8) ire -= xn;
        if (m == 4) iim += (inv_val ? xn : -xn);
        if (m == 12) iim -= (inv_val ? xn : -xn);
      end
      got_re = bus_if.px_o[128*k +: 64];
      got_im = bus_if.px_o[128*k + 64 +: 64];
      if (exact) begin
        check($sformatf("%s_re%0d", tag, k), got_re, $realtobits(real'(ire)));
        check($sformatf("%s_im%0d", tag, k), got_im, $realtobits(real'(iim)));
      end else if (strict_zero) begin
        check($sformatf("%s_re%0d", tag, k), got_re, 64'h0);
        check($sformatf("%s_im%0d", tag, k), got_im, 64'h0);
      end else begin
        check_near($sformatf("%s_re%0d", tag, k), got_re, re, 1.0e-5 * sx + 1.0e-9);
        check_near($sformatf("%s_im%0d", tag, k), got_im, im, 1.0e-5 * sx + 1.0e-9);
      end
    end
  endtask

  task automatic run_xform(input logic [63:0] x, input bit poke, input bit do_rst,
                           output int fd, output int nd);
    bus_if.x_i   = x;
    bus_if.start = 1'b1;
`ifdef DFT_INVERSE_EN
    bus_if.inv   = inv_val;
`endif
    fd = 0;
    nd = 0;
    for (int c = 1; c <= 270; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        bus_if.start = 1'b0;
        check("busy_c1", 64'(bus_if.busy), 64'd1);
      end else begin
        bus_if.x_i = {$urandom, $urandom};
`ifdef DFT_INVERSE_EN
        bus_if.inv = ~inv_val;
`endif
      end
      if (poke && c == 50) bus_if.start = 1'b1;
      if (poke && c == 52) bus_if.start = 1'b0;
      if (do_rst && c == 100) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(bus_if.busy), 64'd0);
        check("rst_px", 64'(|bus_if.px_o), 64'd0);
      end
      if (do_rst && c == 103) rst_n = 1'b1;
      if (bus_if.done === 1'b1) begin
        nd++;
        if (fd == 0) fd = c;
      end
      if (c == 258) check("busy_c258", 64'(bus_if.busy), 64'd0);
    end
  endtask

  initial begin
    bus_if.start = 1'b0;
    bus_if.x_i   = '0;
`ifdef DFT_INVERSE_EN
    bus_if.inv   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(bus_if.busy), 64'd0);
    check("reset_done", 64'(bus_if.done), 64'd0);
    check("reset_px", 64'(|bus_if.px_o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_xform(64'h0, 1'b0, 1'b0, first_done, n_done);
    check("zero_done_cyc", 64'(first_done), 64'd257);
    check("zero_done_cnt", 64'(n_done), 64'd1);
    check("zero_px", 64'(|bus_if.px_o), 64'd0);

    run_xform(64'h5, 1'b0, 1'b0, first_done, n_done);
    check("imp_done_cyc", 64'(first_done), 64'd257);
    check("imp_re3_const", bus_if.px_o[128*3 +: 64], 64'h4014000000000000);
    check_bins("imp", 64'h5, 1'b0);

    run_xform(64'h1111_1111_1111_1111, 1'b0, 1'b0, first_done, n_done);
    check("ones_re0_const", bus_if.px_o[63:0], 64'h4030000000000000);
    check_bins("ones", 64'h1111_1111_1111_1111, 1'b1);

    run_xform(64'h0000_0000_8765_4321, 1'b0, 1'b0, first_done, n_done);
    check("ramp_re0", bus_if.px_o[128*0 +: 64], $realtobits(36.0));
    check("ramp_re4", bus_if.px_o[128*4 +: 64], $realtobits(-4.0));
    check("ramp_im4", bus_if.px_o[128*4 + 64 +: 64], $realtobits(4.0));
    check("ramp_re8", bus_if.px_o[128*8 +: 64], $realtobits(-4.0));
    check("ramp_im12", bus_if.px_o[128*12 + 64 +: 64], $realtobits(-4.0));
    check_bins("ramp", 64'h0000_0000_8765_4321, 1'b0);

    xv = {$urandom, $urandom};
    run_xform(xv, 1'b1, 1'b0, first_done, n_done);
    check("poke_done_cyc", 64'(first_done), 64'd257);
    check("poke_done_cnt", 64'(n_done), 64'd1);
    check_bins("poke", xv, 1'b0);

    xv = {$urandom, $urandom};
    run_xform(xv, 1'b0, 1'b1, first_done, n_done);
    check("rst_done_cnt", 64'(n_done), 64'd0);

    for (int r = 0; r < 3; r++) begin
      xv = {$urandom, $urandom};
`ifdef DFT_INVERSE_EN
      inv_val = (r == 1);
`endif
      run_xform(xv, 1'b0, 1'b0, first_done, n_done);
      check($sformatf("rnd%0d_done_cyc", r), 64'(first_done), 64'd257);
      check_bins($sformatf("rnd%0d", r), xv, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
